wb_mem_slave: RTL

- Wishbone classic slave that sits directly downstream of wb_interconnect's slave port.
- Drives the single-port-style interface of dpram64: we_d, din_d, waddr_d/raddr_d, dout_d.
- Replaces the bench's ad-hoc "ack = registered cyc" logic with correct read latency, configurable wait states, range checking and error response.
- Implements byte-lane writes (sel != 4'hF) as read-modify-write, because the memory has no byte enables.

---
 rtl/wb_mem_pkg.sv | 19 +
 rtl/wb_mem_slave_byte_merge.sv | 19 +
 rtl/wb_mem_slave.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/wb_mem_pkg.sv
// Shared types and constants for the Wishbone memory slave.
package wb_mem_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int SEL_WIDTH          = DEFAULT_DATA_WIDTH / 8;
  localparam int WS_CNT_WIDTH       = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERR     = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_DATA = 3'd3,
    S_RMW_RD  = 3'd4,
    S_RMW_WR  = 3'd5,
    S_WR      = 3'd6,
    S_ACK     = 3'd7
  } wb_mem_state_e;

endpackage

// File: rtl/wb_mem_slave_byte_merge.sv
// Per-byte-lane merge: lanes with sel set take the new word, the rest keep the old word.
module wb_mem_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_i,
  input  logic [DATA_WIDTH-1:0]   new_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic [DATA_WIDTH-1:0]   merged_o
);

  // Lane-by-lane select between old and new data.
  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      if (sel_i[i]) merged_o[i*8 +: 8] = new_i[i*8 +: 8];
    end
  end

endmodule

// File: rtl/wb_mem_slave.sv
// Wishbone classic slave in front of a memory with one-cycle read latency and
// no byte enables. Partial writes become read-modify-write.
//
// Handshake: a request is taken in IDLE on any edge where cyc & stb are high.
// The slave answers with exactly one cycle of ack (or err, never both) and then
// returns to IDLE; the master must drop stb on the edge that samples ack/err.
// Dropping cyc in any busy state abandons the transfer without ack/err, and a
// memory write that has not yet been issued is then never issued.
module wb_mem_slave
  import wb_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_SIZE    = 1 << 18,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   wbd_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbd_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wbd_sel_i,
  input  logic                    wbd_we_i,
  input  logic                    wbd_cyc_i,
  input  logic                    wbd_stb_i,
  output logic [DATA_WIDTH-1:0]   wbd_dat_o,
  output logic                    wbd_ack_o,
  output logic                    wbd_err_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_din_o,
  input  logic [DATA_WIDTH-1:0]   mem_dout_i
);

  localparam int                      SW        = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0]   MEM_LIMIT = ADDR_WIDTH'(MEM_SIZE);
  localparam logic [WS_CNT_WIDTH-1:0] WS_LOAD   = WS_CNT_WIDTH'(WAIT_STATES);

  // FSM state; state_q is the observation point for checkers.
  wb_mem_state_e           state_q, state_d;
  logic [WS_CNT_WIDTH-1:0] cnt_q, cnt_d;
  // Second RMW_RD phase: counter expired, read data now valid.
  logic                    rmw_ph_q, rmw_ph_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   din_q, din_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   merged;

  wb_mem_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_i    (mem_dout_i),
    .new_i    (din_q),
    .sel_i    (sel_q),
    .merged_o (merged)
  );

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rmw_ph_q <= 1'b0;
      sel_q    <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      dat_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rmw_ph_q <= rmw_ph_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      dat_q    <= dat_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  // Next-state and next-register logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rmw_ph_d = rmw_ph_q;
    sel_d    = sel_q;
    addr_d   = addr_q;
    din_d    = din_q;
    dat_d    = dat_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wbd_cyc_i && wbd_stb_i) begin
          addr_d   = {wbd_adr_i[ADDR_WIDTH-1:2], 2'b00};
          din_d    = wbd_dat_i;
          sel_d    = wbd_sel_i;
          cnt_d    = WS_LOAD;
          rmw_ph_d = 1'b0;
          if (wbd_adr_i >= MEM_LIMIT) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end else if (!wbd_we_i) begin
            state_d = S_RD_WAIT;
          end else if ((&wbd_sel_i) || (wbd_sel_i == '0)) begin
            state_d = S_WR;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_ERR: state_d = S_IDLE;
      S_RD_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        dat_d   = mem_dout_i;
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_RMW_RD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rmw_ph_q) begin
          rmw_ph_d = 1'b1;
        end else begin
          din_d   = merged;
          state_d = S_RMW_WR;
        end
      end
      S_RMW_WR: begin
        ack_d   = 1'b1;
        state_d = S_ACK;
      end
      S_WR: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Master abandoned the cycle: go idle silently, keep the old read data.
    if (state_q != S_IDLE && !wbd_cyc_i) begin
      state_d = S_IDLE;
      ack_d   = 1'b0;
      err_d   = 1'b0;
      dat_d   = dat_q;
    end
  end

  // Write strobe is combinational so abort and reset cancel it in the same cycle.
  always_comb begin
    mem_we_o = 1'b0;
    if (!reset && wbd_cyc_i) begin
      if (state_q == S_RMW_WR) mem_we_o = 1'b1;
      if (state_q == S_WR && cnt_q == '0 && sel_q != '0) mem_we_o = 1'b1;
    end
  end

  assign wbd_dat_o  = dat_q;
  assign wbd_ack_o  = ack_q;
  assign wbd_err_o  = err_q;
  assign mem_addr_o = addr_q;
  assign mem_din_o  = din_q;

endmodule
